spy_fc_reader: RTL
==================

SPY_FC_READER -- requirements
Module: spy_fc_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 64, payload width; the input word is DATA_WIDTH+1 bits, MSB = end-of-event metadata flag.
REQ-002 Parameter MAX_EVENT_WORDS, default 256, maximum words per event before truncation.
REQ-003 Parameter COUNT_WIDTH, default 16, width of the statistics counters.
REQ-004 clock  input  1  single clock, the flow-control buffer read clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  DATA_WIDTH+1  buffer read data, first-word-fall-through, valid whenever in_empty=0.
REQ-007 in_empty  input  1  buffer empty flag.
REQ-008 in_read_enable  output  1  pops one word from the buffer in the cycle it is high.
REQ-009 out_data  output  DATA_WIDTH  payload of the downstream stream (metadata bit stripped).
REQ-010 out_valid / out_ready  output / input  1 / 1  stream handshake; a transfer occurs on a clock edge with both high.
REQ-011 out_last  output  1  last word of an event.
REQ-012 out_trunc  output  1  qualifies out_last; high only on a forced (truncated) last word.
REQ-013 event_count, trunc_count  output  COUNT_WIDTH each  completed events and truncated events.

Function
REQ-014 in_read_enable = !in_empty && !reset && (state==DISCARD || output buffer holds <2 entries || (holds 2 && out_ready && out_valid)).
REQ-015 A popped word shall appear on out_data/out_valid in the next cycle when the buffer was empty (latency 1); otherwise order is preserved, FIFO order.
REQ-016 Output buffer: 2 entries; out_data/out_last/out_trunc held stable while out_valid=1 and out_ready=0.
REQ-017 States: IDLE (no open event), BODY (event open), DISCARD (dropping truncated remainder).
REQ-018 IDLE: popped word with flag=0 -> emit, word_cnt=1, go BODY; flag=1 -> emit with out_last=1, event_count+1, stay IDLE.
REQ-019 BODY: flag=1 -> emit with out_last=1, event_count+1, word_cnt=0, go IDLE.
REQ-020 BODY: flag=0 and word_cnt==MAX_EVENT_WORDS-1 -> emit with out_last=1, out_trunc=1, event_count+1, trunc_count+1, go DISCARD; else emit, word_cnt+1.
REQ-021 DISCARD: words popped without emission; a word with flag=1 is also dropped and returns to IDLE.
REQ-022 word_cnt width = clog2(MAX_EVENT_WORDS+1); counters wrap modulo 2^COUNT_WIDTH.
REQ-023 Simultaneous pop and downstream transfer with buffer full shall lose no word and duplicate none.

Reset
REQ-024 During reset: in_read_enable=0, out_valid=0, out_last=0, out_trunc=0, out_data=0, counters=0, state=IDLE, buffer empty.
REQ-025 Reset mid-event discards the partial event; the first popped word after reset is treated as the start of a new event.

Configuration
REQ-026 Macro SPY_FC_READER_STATS_EN: defined -> event_count/trunc_count operate per REQ-018..022; undefined -> both outputs tied to 0, no counter registers; stream behaviour identical.

Structure
REQ-027 Package spy_fc_reader_pkg: state enumeration (IDLE, BODY, DISCARD) and the output-entry record (data, last, trunc).
REQ-028 Sub-module spy_fc_skid: the 2-entry output buffer with valid/ready handshake.

Verification
REQ-029 Event of 3 words (flags 0,0,1), out_ready=1 -> 3 transfers, out_last on 3rd only, event_count=1, first out_valid 1 cycle after first pop.
REQ-030 MAX_EVENT_WORDS=4, event of 6 words -> 4 transfers, 4th has out_last=out_trunc=1, words 5-6 dropped, trunc_count=1, next event passes intact.
REQ-031 out_ready=0 for 10 cycles with 5 words queued -> exactly 2 pops, out_data stable; release -> all 5 delivered in order.
REQ-032 Single-word event (flag=1) in IDLE -> one transfer with out_last=1, event_count=1.
REQ-033 reset asserted mid-event after 2 of 4 words -> all outputs 0 during reset, counters 0; next event after release delivered complete.
REQ-034 Build without SPY_FC_READER_STATS_EN, rerun REQ-029 -> identical stream, counters read 0.

Source files
------------

// File: rtl/spy_fc_reader_pkg.sv
// Shared types for spy_fc_reader: event-framing states and the tag carried with each output word.
package spy_fc_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BODY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  // Framing metadata travelling with each buffered output word.
  typedef struct packed {
    logic last;
    logic trunc;
  } out_tag_t;

endpackage

// File: rtl/spy_fc_skid.sv
// Two-entry output buffer: a push appears at out_dat one cycle later; head is held stable while out_rdy=0.
module spy_fc_skid #(
  parameter int unsigned W = 66
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic [1:0]   fill,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   fill_q, fill_d;
  logic         pop;

  assign pop = (fill_q != 2'd0) && out_rdy;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    unique case ({push_vld, pop})
      2'b10: begin
        if (fill_q == 2'd0) head_d = push_dat;
        else                tail_d = push_dat;
        fill_d = fill_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        fill_d = fill_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains after the pop.
        if (fill_q == 2'd1) begin
          head_d = push_dat;
        end else begin
          head_d = tail_q;
          tail_d = push_dat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
    end
  end

  assign fill    = fill_q;
  assign out_vld = (fill_q != 2'd0);
  assign out_dat = head_q;

endmodule

// File: rtl/spy_fc_reader.sv
// Drains a FWFT flow-control buffer into a framed valid/ready stream, truncating events at MAX_EVENT_WORDS.
// Pop-to-valid latency 1; a 2-entry skid absorbs out_ready stalls. SPY_FC_READER_STATS_EN enables the counters.
module spy_fc_reader
  import spy_fc_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_EVENT_WORDS = 256,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH:0]    in_data,
  input  logic                   in_empty,
  output logic                   in_read_enable,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   out_trunc,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic [COUNT_WIDTH-1:0] trunc_count
);

  localparam int unsigned WCW = $clog2(MAX_EVENT_WORDS + 1);
  localparam int unsigned EW  = DATA_WIDTH + $bits(out_tag_t);

  state_e          state_q, state_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic            pop, flag, at_limit;
  logic            push_vld, ev_inc, tr_inc;
  out_tag_t        push_tag, out_tag;
  logic [1:0]      fill;
  logic [EW-1:0]   out_ent;

  assign flag     = in_data[DATA_WIDTH];
  assign at_limit = (word_cnt_q == WCW'(MAX_EVENT_WORDS - 1));

  // DISCARD never pushes, so it may pop regardless of downstream space.
  assign pop = !in_empty && !reset &&
               (state_q == ST_DISCARD || fill < 2'd2 ||
                (fill == 2'd2 && out_ready && out_valid));
  assign in_read_enable = pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pop) begin
      unique case (state_q)
        ST_IDLE:    if (!flag) state_d = ST_BODY;
        ST_BODY: begin
          if (flag)          state_d = ST_IDLE;
          else if (at_limit) state_d = ST_DISCARD;
        end
        ST_DISCARD: if (flag) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_vld   = 1'b0;
    push_tag   = '0;
    word_cnt_d = word_cnt_q;
    ev_inc     = 1'b0;
    tr_inc     = 1'b0;
    if (pop) begin
      unique case (state_q)
        ST_IDLE: begin
          push_vld = 1'b1;
          if (flag) begin
            push_tag.last = 1'b1;
            ev_inc        = 1'b1;
            word_cnt_d    = '0;
          end else begin
            word_cnt_d = WCW'(1);
          end
        end
        ST_BODY: begin
          push_vld = 1'b1;
          if (flag) begin
            push_tag.last = 1'b1;
            ev_inc        = 1'b1;
            word_cnt_d    = '0;
          end else if (at_limit) begin
            push_tag.last  = 1'b1;
            push_tag.trunc = 1'b1;
            ev_inc         = 1'b1;
            tr_inc         = 1'b1;
            word_cnt_d     = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  spy_fc_skid #(.W(EW)) u_skid (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat ({in_data[DATA_WIDTH-1:0], push_tag}),
    .fill     (fill),
    .out_vld  (out_valid),
    .out_rdy  (out_ready),
    .out_dat  (out_ent)
  );

  assign {out_data, out_tag} = out_ent;
  assign out_last  = out_tag.last;
  assign out_trunc = out_tag.trunc;

`ifdef SPY_FC_READER_STATS_EN
  logic [COUNT_WIDTH-1:0] event_count_q, event_count_d;
  logic [COUNT_WIDTH-1:0] trunc_count_q, trunc_count_d;

  always_comb begin
    event_count_d = event_count_q + COUNT_WIDTH'(ev_inc);
    trunc_count_d = trunc_count_q + COUNT_WIDTH'(tr_inc);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      event_count_q <= '0;
      trunc_count_q <= '0;
    end else begin
      event_count_q <= event_count_d;
      trunc_count_q <= trunc_count_d;
    end
  end

  assign event_count = event_count_q;
  assign trunc_count = trunc_count_q;
`else
  logic unused_stats;
  assign unused_stats = ev_inc ^ tr_inc;
  assign event_count  = '0;
  assign trunc_count  = '0;
`endif

endmodule
